// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit and memory.
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: PC, imem request FSM and one-entry output slot feeding IF/ID.
// Optional perf counters when FETCH_PERF_CNT_EN is defined.
module fetch_unit (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic [31:0]         inst,
  output logic [31:0]         add_pc,
  output logic                valid,
  output logic                ifid_load,
  output logic                flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    READY,
    REQ,
    DRAIN
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc;
  logic [31:0] hold_addr;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        slot_ok;
  logic        issue;
  logic        load;

  assign pc_inc    = pc + 32'd4;
  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign ifid_load = valid & ~stall;
  assign flush     = redirect;
  assign slot_ok   = ~valid | ifid_load;
  assign issue     = (state == READY) & slot_ok & ~redirect;

  assign imem.imem_req  = issue | (state == REQ) | (state == DRAIN);
  // An abandoned request keeps its address until memory acks it.
  assign imem.imem_addr = (state == DRAIN) ? hold_addr : pc;

  // Next-state and slot-load decision.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    unique case (state)
      IDLE:  state_d = READY;
      READY: begin
        if (issue) begin
          if (imem.imem_ack) load    = 1'b1;
          else               state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          state_d = imem.imem_ack ? READY : DRAIN;
        end else if (imem.imem_ack) begin
          load    = 1'b1;
          state_d = READY;
        end
      end
      DRAIN: begin
        if (imem.imem_ack) state_d = READY;
      end
    endcase
  end

  // State, PC and output slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= 32'd0;
      hold_addr <= 32'd0;
      inst      <= 32'd0;
      add_pc    <= 32'd0;
      valid     <= 1'b0;
    end else begin
      state <= state_d;
      if ((state == REQ) && redirect && !imem.imem_ack)
        hold_addr <= pc;
      if (redirect) begin
        pc    <= target;
        valid <= 1'b0;
      end else if (load) begin
        inst   <= imem.imem_rdata;
        add_pc <= pc_inc;
        pc     <= pc_inc;
        valid  <= 1'b1;
      end else if (ifid_load) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating fetch and bubble counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (ifid_load && fetch_cnt != 32'hFFFF_FFFF)
        fetch_cnt <= fetch_cnt + 32'd1;
      if ((!valid || stall) && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
